// File: rtl/fsctl_axi_pkg.sv
// Shared AXI4-Lite response codes and FSM state types for the frame-stitch
// controller register bridge.
package fsctl_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_CAP, R_RESP} rd_state_e;

endpackage

// File: rtl/fsctl_axilite_bridge_if.sv
// AXI4-Lite bus between the PS interconnect (master) and the controller
// register bridge (slave).
interface fsctl_axilite_bridge_if #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 8
);

  logic [C_ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic                      s_axi_awvalid;
  logic                      s_axi_awready;
  logic [C_DATA_WIDTH-1:0]   s_axi_wdata;
  logic [C_DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                      s_axi_wvalid;
  logic                      s_axi_wready;
  logic [1:0]                s_axi_bresp;
  logic                      s_axi_bvalid;
  logic                      s_axi_bready;
  logic [C_ADDR_WIDTH-1:0]   s_axi_araddr;
  logic                      s_axi_arvalid;
  logic                      s_axi_arready;
  logic [C_DATA_WIDTH-1:0]   s_axi_rdata;
  logic [1:0]                s_axi_rresp;
  logic                      s_axi_rvalid;
  logic                      s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    output s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

  modport master (
    output s_axi_awaddr, s_axi_awvalid, s_axi_wdata, s_axi_wstrb, s_axi_wvalid,
           s_axi_bready, s_axi_araddr, s_axi_arvalid, s_axi_rready,
    input  s_axi_awready, s_axi_wready, s_axi_bresp, s_axi_bvalid,
           s_axi_arready, s_axi_rdata, s_axi_rresp, s_axi_rvalid
  );

endinterface

// File: rtl/fsctl_axilite_bridge.sv
// AXI4-Lite slave driving the frame-stitch controller register file through
// independent, fully registered write and read state machines.
module fsctl_axilite_bridge
  import fsctl_axi_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_ADDR_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    resetn,
  fsctl_axilite_bridge_if.slave   s_axi,
  output logic                    wr_en,
  output logic [C_ADDR_WIDTH-1:0] wr_addr,
  output logic [C_DATA_WIDTH-1:0] wr_data,
  output logic [C_ADDR_WIDTH-1:0] rd_addr,
  input  logic [C_DATA_WIDTH-1:0] rd_data
);

  localparam int STRB_W = C_DATA_WIDTH / 8;

  wr_state_e               wr_state_q;
  logic                    awready_q, wready_q, aw_held_q, w_held_q;
  logic [C_ADDR_WIDTH-1:0] awaddr_q, wr_addr_q;
  logic [C_DATA_WIDTH-1:0] wdata_q, wr_data_q;
  logic [STRB_W-1:0]       wstrb_q;
  logic                    bvalid_q, wr_en_q;
  logic [1:0]              bresp_q;

  rd_state_e               rd_state_q;
  logic                    arready_q, rvalid_q;
  logic [C_ADDR_WIDTH-1:0] rd_addr_q;
  logic [C_DATA_WIDTH-1:0] rdata_q;
  logic [1:0]              rresp_q;

  logic                    aw_hs, w_hs, aw_have_d, w_have_d, ar_hs;
  logic [C_ADDR_WIDTH-1:0] awaddr_d;
  logic [C_DATA_WIDTH-1:0] wdata_d;
  logic [STRB_W-1:0]       wstrb_d;

  // A beat arriving this cycle is merged with any beat already held.
  always_comb begin
    aw_hs     = s_axi.s_axi_awvalid & awready_q;
    w_hs      = s_axi.s_axi_wvalid & wready_q;
    ar_hs     = s_axi.s_axi_arvalid & arready_q;
    aw_have_d = aw_held_q | aw_hs;
    w_have_d  = w_held_q | w_hs;
    awaddr_d  = aw_hs ? s_axi.s_axi_awaddr : awaddr_q;
    wdata_d   = w_hs ? s_axi.s_axi_wdata : wdata_q;
    wstrb_d   = w_hs ? s_axi.s_axi_wstrb : wstrb_q;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      case (wr_state_q)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held_q <= 1'b1;
            awaddr_q  <= s_axi.s_axi_awaddr;
          end
          if (w_hs) begin
            w_held_q <= 1'b1;
            wdata_q  <= s_axi.s_axi_wdata;
            wstrb_q  <= s_axi.s_axi_wstrb;
          end
          if (aw_have_d && w_have_d) begin
            wr_state_q <= W_EXEC;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            // Partial-strobe writes never reach the register file.
            wr_en_q    <= &wstrb_d;
            if (&wstrb_d) begin
              wr_addr_q <= awaddr_d;
              wr_data_q <= wdata_d;
            end
          end else begin
            awready_q <= ~aw_have_d;
            wready_q  <= ~w_have_d;
          end
        end
        W_EXEC: begin
          wr_en_q    <= 1'b0;
          bresp_q    <= wr_en_q ? RESP_OKAY : RESP_SLVERR;
          bvalid_q   <= 1'b1;
          wr_state_q <= W_RESP;
        end
        W_RESP: begin
          if (s_axi.s_axi_bready) begin
            bvalid_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            wr_state_q <= W_IDLE;
          end
        end
        default: wr_state_q <= W_IDLE;
      endcase
    end
  end

  // rd_data is combinational from rd_addr, so it is sampled one cycle after
  // the address is registered; a same-cycle write lands after the sample.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rd_addr_q  <= '0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      case (rd_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            rd_addr_q  <= s_axi.s_axi_araddr;
            arready_q  <= 1'b0;
            rd_state_q <= R_CAP;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_CAP: begin
          rdata_q    <= rd_data;
          rresp_q    <= RESP_OKAY;
          rvalid_q   <= 1'b1;
          rd_state_q <= R_RESP;
        end
        R_RESP: begin
          if (s_axi.s_axi_rready) begin
            rvalid_q   <= 1'b0;
            arready_q  <= 1'b1;
            rd_state_q <= R_IDLE;
          end
        end
        default: rd_state_q <= R_IDLE;
      endcase
    end
  end

  assign s_axi.s_axi_awready = awready_q;
  assign s_axi.s_axi_wready  = wready_q;
  assign s_axi.s_axi_bvalid  = bvalid_q;
  assign s_axi.s_axi_bresp   = bresp_q;
  assign s_axi.s_axi_arready = arready_q;
  assign s_axi.s_axi_rvalid  = rvalid_q;
  assign s_axi.s_axi_rdata   = rdata_q;
  assign s_axi.s_axi_rresp   = rresp_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: tb/tb_fsctl_axilite_bridge.sv
// Directed and randomized bench for fsctl_axilite_bridge with a word-addressed
// reference memory and a behavioural register file behind the bridge.
module tb_fsctl_axilite_bridge;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  fsctl_axilite_bridge_if #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(8)) axi ();

  logic        wr_en;
  logic [7:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;

  fsctl_axilite_bridge #(.C_DATA_WIDTH(32), .C_ADDR_WIDTH(8)) dut (
    .clk    (clk),
    .resetn (resetn),
    .s_axi  (axi),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Register file seen by the bridge: byte address, word indexed.
  logic [31:0] rf [64] = '{default: '0};
  always @(posedge clk) if (wr_en) rf[wr_addr[7:2]] <= wr_data;
  assign rd_data = rf[rd_addr[7:2]];

  // Reference: contents of completed full-strobe writes, plus last wr port value.
  logic [31:0] ref_mem [int];
  logic [7:0]  last_addr = '0;
  logic [31:0] last_data = '0;
  logic [7:0]  used_q [$];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] ref_read(input logic [7:0] a);
    int k = int'(a >> 2);
    return ref_mem.exists(k) ? ref_mem[k] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // lead > 0: W beat that many cycles before AW; lead < 0: AW first.
  task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, input int bdly);
    int gap = (lead < 0) ? -lead : lead;
    logic full = &s;
    @(posedge clk); #1;
    if (lead != 0) begin
      if (lead > 0) begin
        axi.s_axi_wvalid = 1'b1; axi.s_axi_wdata = d; axi.s_axi_wstrb = s;
      end else begin
        axi.s_axi_awvalid = 1'b1; axi.s_axi_awaddr = a;
      end
      @(negedge clk);
      chk("first_rdy", (lead > 0) ? axi.s_axi_wready : axi.s_axi_awready, 1);
      @(posedge clk); #1;
      axi.s_axi_wvalid = 1'b0; axi.s_axi_awvalid = 1'b0;
      for (int i = 1; i < gap; i++) begin
        @(negedge clk);
        chk("gap_wready", axi.s_axi_wready, (lead < 0) ? 1 : 0);
        chk("gap_awready", axi.s_axi_awready, (lead > 0) ? 1 : 0);
        chk("gap_wr_en", wr_en, 0);
        @(posedge clk); #1;
      end
    end
    if (lead <= 0) begin
      axi.s_axi_wvalid = 1'b1; axi.s_axi_wdata = d; axi.s_axi_wstrb = s;
    end
    if (lead >= 0) begin
      axi.s_axi_awvalid = 1'b1; axi.s_axi_awaddr = a;
    end
    @(negedge clk);
    chk("hs_awready", axi.s_axi_awready, (lead >= 0) ? 1 : 0);
    chk("hs_wready", axi.s_axi_wready, (lead <= 0) ? 1 : 0);
    chk("hs_wr_en", wr_en, 0);
    @(posedge clk); #1;
    axi.s_axi_wvalid = 1'b0; axi.s_axi_awvalid = 1'b0;
    if (full) begin
      ref_mem[int'(a >> 2)] = d;
      last_addr = a;
      last_data = d;
    end
    @(negedge clk);
    chk("t1_wr_en", wr_en, full);
    chk("t1_wr_addr", wr_addr, last_addr);
    chk("t1_wr_data", wr_data, last_data);
    chk("t1_bvalid", axi.s_axi_bvalid, 0);
    chk("t1_readies", {axi.s_axi_awready, axi.s_axi_wready}, 0);
    @(posedge clk); #1;
    axi.s_axi_bready = (bdly == 0);
    @(negedge clk);
    chk("t2_wr_en", wr_en, 0);
    chk("t2_bvalid", axi.s_axi_bvalid, 1);
    chk("t2_bresp", axi.s_axi_bresp, full ? 2'b00 : 2'b10);
    for (int i = 0; i < bdly; i++) begin
      @(posedge clk); #1;
      if (i == bdly - 1) axi.s_axi_bready = 1'b1;
      @(negedge clk);
      chk("bp_bvalid", axi.s_axi_bvalid, 1);
      chk("bp_bresp", axi.s_axi_bresp, full ? 2'b00 : 2'b10);
      chk("bp_readies", {axi.s_axi_awready, axi.s_axi_wready, wr_en}, 0);
    end
    @(posedge clk); #1;
    axi.s_axi_bready = 1'b0;
    @(negedge clk);
    chk("done_bvalid", axi.s_axi_bvalid, 0);
    chk("done_readies", {axi.s_axi_awready, axi.s_axi_wready}, 2'b11);
  endtask

  task automatic do_read(input logic [7:0] a, input int rdly, input logic [31:0] exp);
    @(posedge clk); #1;
    axi.s_axi_arvalid = 1'b1; axi.s_axi_araddr = a;
    @(negedge clk);
    chk("ar_arready", axi.s_axi_arready, 1);
    @(posedge clk); #1;
    axi.s_axi_arvalid = 1'b0;
    @(negedge clk);
    chk("r1_rd_addr", rd_addr, a);
    chk("r1_rvalid", axi.s_axi_rvalid, 0);
    chk("r1_arready", axi.s_axi_arready, 0);
    @(posedge clk); #1;
    axi.s_axi_rready = (rdly == 0);
    @(negedge clk);
    chk("r2_rvalid", axi.s_axi_rvalid, 1);
    chk("r2_rdata", axi.s_axi_rdata, exp);
    chk("r2_rresp", axi.s_axi_rresp, 0);
    for (int i = 0; i < rdly; i++) begin
      @(posedge clk); #1;
      if (i == rdly - 1) axi.s_axi_rready = 1'b1;
      @(negedge clk);
      chk("rbp_rvalid", axi.s_axi_rvalid, 1);
      chk("rbp_rdata", axi.s_axi_rdata, exp);
      chk("rbp_arready", axi.s_axi_arready, 0);
    end
    @(posedge clk); #1;
    axi.s_axi_rready = 1'b0;
    @(negedge clk);
    chk("rdone_rvalid", axi.s_axi_rvalid, 0);
    chk("rdone_arready", axi.s_axi_arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish, expected finish before timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] old_val;
    axi.s_axi_awaddr = '0; axi.s_axi_awvalid = 1'b0;
    axi.s_axi_wdata = '0;  axi.s_axi_wstrb = '0; axi.s_axi_wvalid = 1'b0;
    axi.s_axi_bready = 1'b0;
    axi.s_axi_araddr = '0; axi.s_axi_arvalid = 1'b0; axi.s_axi_rready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_readies", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 0);
    chk("rst_valids", {axi.s_axi_bvalid, axi.s_axi_rvalid, wr_en}, 0);
    chk("rst_resps", {axi.s_axi_bresp, axi.s_axi_rresp}, 0);
    chk("rst_rdata", axi.s_axi_rdata, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_addrs", {wr_addr, rd_addr}, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    chk("prerise_readies", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 0);
    @(posedge clk);
    @(negedge clk);
    chk("rise_readies", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 3'b111);

    do_write(8'h08, 32'hDEADBEEF, 4'hF, 0, 0);
    do_write(8'h10, 32'hCAFEF00D, 4'hF, 3, 0);
    do_write(8'h14, 32'h0BADF00D, 4'h3, 0, 1);
    do_write(8'h04, 32'h12345678, 4'hF, -2, 2);
    do_read(8'h04, 5, ref_read(8'h04));
    do_read(8'h08, 0, ref_read(8'h08));
    do_read(8'h14, 0, ref_read(8'h14));

    old_val = ref_read(8'h0C);
    fork
      do_write(8'h0C, 32'h5, 4'hF, 0, 0);
      do_read(8'h0C, 0, old_val);
    join
    chk("coll_old_val", old_val, 32'h0);
    do_read(8'h0C, 1, ref_read(8'h0C));

    // Reset with the AW beat held and the W beat still outstanding.
    @(posedge clk); #1;
    axi.s_axi_awvalid = 1'b1; axi.s_axi_awaddr = 8'h20;
    @(posedge clk); #1;
    axi.s_axi_awvalid = 1'b0;
    resetn = 1'b0;
    @(negedge clk);
    chk("pre_rst_held", {axi.s_axi_awready, axi.s_axi_wready}, 2'b01);
    @(posedge clk); #1;
    resetn = 1'b1;
    last_addr = '0;
    last_data = '0;
    @(negedge clk);
    chk("mid_rst_readies", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 0);
    chk("mid_rst_out", {axi.s_axi_bvalid, wr_en}, 0);
    chk("mid_rst_wr_addr", wr_addr, 0);
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_readies", {axi.s_axi_awready, axi.s_axi_wready, axi.s_axi_arready}, 3'b111);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("post_rst_quiet", {axi.s_axi_bvalid, wr_en}, 0);
    end
    do_write(8'h24, 32'hA5A5_5A5A, 4'hF, 0, 0);
    do_read(8'h24, 0, ref_read(8'h24));

    for (int n = 0; n < 16; n++) begin
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      s = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
      used_q.push_back(a);
      do_write(a, d, s, int'($urandom_range(0, 6)) - 3, int'($urandom_range(0, 2)));
    end
    for (int n = 0; n < 12; n++) begin
      a = used_q[$urandom_range(0, used_q.size() - 1)];
      do_read(a, int'($urandom_range(0, 3)), ref_read(a));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fsctl_axilite_bridge.md
# fsctl_axilite_bridge

AXI4-Lite slave that terminates the processor's register bus and drives the simple register-file port of the frame-stitch controller: `rd_addr`/`rd_data` and `wr_en`/`wr_addr`/`wr_data`. It sits between the PS interconnect and the controller register file. Write and read channels run as independent state machines, because the register file has separate read and write ports. Each transaction completes in a fixed, short cycle count.

## Interface
Parameters:
- C_DATA_WIDTH, 32: AXI data width and register width.
- C_ADDR_WIDTH, 8: byte address width, forwarded unchanged to the register file.

Ports. Reset is `resetn`, synchronous, active-low; the clock is `clk`.
- clk  in  1  clock.
- resetn  in  1  synchronous active-low reset.
- s_axi_awaddr  in  C_ADDR_WIDTH  write address.
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake.
- s_axi_wdata  in  C_DATA_WIDTH  write data.
- s_axi_wstrb  in  C_DATA_WIDTH/8  byte strobes.
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake.
- s_axi_araddr  in  C_ADDR_WIDTH  read address.
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake.
- s_axi_rdata  out  C_DATA_WIDTH  read data.
- s_axi_rresp  out  2  read response, always OKAY.
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake.
- wr_en  out  1  one-cycle write pulse to the register file.
- wr_addr  out  C_ADDR_WIDTH  register-file write byte address.
- wr_data  out  C_DATA_WIDTH  register-file write data.
- rd_addr  out  C_ADDR_WIDTH  register-file read byte address.
- rd_data  in  C_DATA_WIDTH  combinational read data from the register file.

## Operation
Write FSM, states W_IDLE → W_EXEC → W_RESP → W_IDLE:
- W_IDLE:
  - AW and W beats are captured independently, in either order.
  - awready is high while no AW beat is held; wready is high while no W beat is held.
  - Each ready drops in the cycle after its own handshake.
  - When both beats are held, the FSM moves to W_EXEC.
- W_EXEC, one cycle:
  - If wstrb is all ones: wr_en=1, with wr_addr and wr_data set from the captured beats; bresp latched as OKAY (2'b00).
  - Otherwise: wr_en stays 0 and bresp is latched as SLVERR (2'b10). Partial writes are unsupported.
- W_RESP: bvalid=1 until bready is sampled high, then the FSM returns to W_IDLE with both readies high again.

Read FSM, states R_IDLE → R_CAP → R_RESP → R_IDLE:
- R_IDLE: arready=1. On the AR handshake, rd_addr is loaded from araddr.
- R_CAP: rdata is loaded from rd_data.
- R_RESP: rvalid=1 with rresp=OKAY, held until rready.

Register and response rules:
- wr_addr, wr_data and rd_addr hold their last value between transactions.
- Address LSBs are passed through untouched; the register file performs the word indexing.
- A read and a write to the same register in the same cycle (R_CAP coincides with W_EXEC) return the old value.
- Reset asserted mid-transaction: both FSMs return to idle, held beats are dropped, and no wr_en is issued.

## Timing
- Reset values:
  - awready, wready, arready = 0; each rises at the first edge with resetn high.
  - bvalid, rvalid, wr_en = 0.
  - bresp, rresp, rdata, wr_addr, wr_data, rd_addr = 0.
- All outputs are registered.
- Write latency, with the AW and W handshakes both in cycle T:
  - wr_en in T+1.
  - bvalid in T+2.
  - If bready is high in T+2, readies are high again in T+3.
  - Minimum write period is 3 cycles.
- Write with split beats: the T above is the cycle of the later handshake.
- Read latency, with the AR handshake in cycle T:
  - rd_addr is valid in T+1.
  - rdata and rvalid are valid in T+2.
  - arready is high again in T+3 if rready is high in T+2.
- Backpressure:
  - bvalid/bresp and rvalid/rdata/rresp are held stable until their handshake.
  - No new AW/W beat is accepted while B is pending; no new AR beat is accepted while R is pending.
- wr_en is never high for more than one cycle per write.

## Structure
- Shared package `fsctl_axi_pkg` holds:
  - RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
  - State enums for the write FSM (W_IDLE, W_EXEC, W_RESP) and the read FSM (R_IDLE, R_CAP, R_RESP).
- No sub-module. The two FSMs live in one module as independent sequential processes.
- Top-level integration instantiates this bridge next to the controller register file. Its wr_* and rd_* ports connect one-to-one.

## Test plan
- AW=0x08 and W=0xDEADBEEF (wstrb=0xF) in the same cycle, bready=1 → wr_en pulse of exactly one cycle with wr_addr=0x08 and wr_data=0xDEADBEEF at T+1; bvalid with bresp=OKAY at T+2.
- W beat 3 cycles before the AW beat (addr 0x10) → a single wr_en occurs 1 cycle after the AW handshake; wready stays low after the W handshake until B completes.
- wstrb=0x3 → no wr_en; bresp=SLVERR.
- After writing 0x12345678 to 0x04, AR=0x04 with rready held low for 5 cycles → rdata=0x12345678 and rvalid remain stable throughout; arready stays low until the R handshake.
- Write to 0x0C with old value 0x0 and new value 0x5, timed so that W_EXEC coincides with R_CAP of a read of 0x0C → rdata=0x0; a subsequent read returns 0x5.
- resetn pulsed low for 1 cycle with the AW beat held and the W beat outstanding → no wr_en; bvalid=0; readies are 0 during reset and 1 on the next edge; a fresh write then completes normally.
